dmem_lsu: RTL

Load/store initiator that sits between the riscv32i execute stage and the big-endian data memory. Accepts one byte/halfword/word load or store per transaction and drives the memory's `r_w`/`mem_addr`/`mem_data` port. Collects `mem_out` after the memory's synchronous read latency and returns aligned, sign/zero-extended load data. Sub-word stores use read-modify-write, because the memory has only whole-word writes.

---
 rtl/dmem_lsu.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Load/store initiator between the riscv32i execute stage and a big-endian,
// word-write-only data memory; sub-word stores are done as read-modify-write.
module dmem_lsu #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        r_w,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    input  logic [31:0] mem_out
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, CAP, WR, RESP} state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t      state;
    logic [1:0]  cnt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        bad_req;

    assign req_ready = (state == IDLE);

    always_comb begin
        bad_req = 1'b0;
        case (req_size)
            2'b00:   bad_req = 1'b0;
            2'b01:   bad_req = req_addr[0];
            2'b10:   bad_req = |req_addr[1:0];
            default: bad_req = 1'b1;
        endcase
    end

    // Lane 0 is the most significant byte of the word.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (size)
            2'b00:   extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] size,
                                          input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] m;
        m = w;
        if (size == 2'b00) begin
            case (off)
                2'd0:    m[31:24] = wd[7:0];
                2'd1:    m[23:16] = wd[7:0];
                2'd2:    m[15:8]  = wd[7:0];
                default: m[7:0]   = wd[7:0];
            endcase
        end else if (off[1]) begin
            m[15:0] = wd[15:0];
        end else begin
            m[31:16] = wd[15:0];
        end
        merge = m;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            off_q     <= '0;
            wdata_q   <= '0;
            r_w       <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            r_w       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        uns_q    <= req_unsigned;
                        off_q    <= req_addr[1:0];
                        wdata_q  <= req_wdata;
                        mem_addr <= {req_addr[31:2], 2'b00};
                        if (bad_req) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_we && req_size == 2'b10) begin
                            state    <= WR;
                            r_w      <= 1'b1;
                            mem_data <= req_wdata;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    cnt   <= CNT_INIT;
                    state <= (RD_LAT == 1) ? CAP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) state <= CAP;
                end
                CAP: begin
                    // Read data is consumed directly at the capture edge so the
                    // merged word / load result is registered going into WR / RESP.
                    if (we_q) begin
                        state    <= WR;
                        r_w      <= 1'b1;
                        mem_data <= merge(mem_out, size_q, off_q, wdata_q);
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= extract(mem_out, size_q, off_q, uns_q);
                    end
                end
                WR: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
